// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational ALU: operands are held for SETTLE_CYCLES clocks,
// then W/c/z are registered. Optional accumulator operand: define ALU_ISSUE_ACC_EN.
module alu_issue_stage #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_f,
`ifdef ALU_ISSUE_ACC_EN
    input  logic             in_acc,
`endif

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_c,
    input  logic             alu_z,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_w,
    output logic             out_c,
    output logic             out_z,
    output logic [2:0]       out_f
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone
    } state_e;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_f_q, alu_f_d;
    logic [WIDTH-1:0] out_w_q, out_w_d;
    logic             out_c_q, out_c_d;
    logic             out_z_q, out_z_d;
    logic [2:0]       out_f_q, out_f_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] a_src;

    assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept   = in_valid & in_ready;

`ifdef ALU_ISSUE_ACC_EN
    // The accumulator is the last captured result, which out_w_q already holds.
    assign a_src = in_acc ? out_w_q : in_a;
`else
    assign a_src = in_a;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_f_d     = alu_f_q;
        out_w_d     = out_w_q;
        out_c_d     = out_c_q;
        out_z_d     = out_z_q;
        out_f_d     = out_f_q;
        out_valid_d = out_valid_q;
        capture     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    capture     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept ? StSettle : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            alu_a_d = a_src;
            alu_b_d = in_b;
            alu_f_d = in_f;
            cnt_d   = CntInit;
        end

        if (capture) begin
            out_w_d = alu_w;
            out_c_d = alu_c;
            out_z_d = alu_z;
            out_f_d = alu_f_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= 3'd0;
            out_w_q     <= '0;
            out_c_q     <= 1'b0;
            out_z_q     <= 1'b0;
            out_f_q     <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
            out_w_q     <= out_w_d;
            out_c_q     <= out_c_d;
            out_z_q     <= out_z_d;
            out_f_q     <= out_f_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign out_w     = out_w_q;
    assign out_c     = out_c_q;
    assign out_z     = out_z_q;
    assign out_f     = out_f_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: table-driven ops with a result scoreboard, plus sequences for
// backpressure, back-to-back issue, reset mid-operation, SETTLE_CYCLES=1 and the accumulator.
module tb_alu_issue_stage;

    localparam int unsigned SC = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_w, out_w;
    logic [2:0] in_f, alu_f, out_f;
    logic       alu_c, alu_z, out_c, out_z;
`ifdef ALU_ISSUE_ACC_EN
    logic       in_acc;
`endif

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0] in_a1, in_b1, alu_a1, alu_b1, alu_w1, out_w1;
    logic [2:0] in_f1, alu_f1, out_f1;
    logic       alu_c1, alu_z1, out_c1, out_z1;

    // Behavioural ALU: {carry, W}
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] f);
        case (f)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} + {1'b0, ~b} + 9'd1;
            3'b010:  return {1'b0, a};
            3'b011:  return {1'b0, b};
            3'b100:  return 9'd0;
            3'b101:  return {1'b0, a | b};
            3'b110:  return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {alu_c, alu_w}   = alu_model(alu_a, alu_b, alu_f);
    assign alu_z            = (alu_w == 8'd0);
    assign {alu_c1, alu_w1} = alu_model(alu_a1, alu_b1, alu_f1);
    assign alu_z1           = (alu_w1 == 8'd0);

    alu_issue_stage #(.WIDTH(8), .SETTLE_CYCLES(SC)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_f      (in_f),
`ifdef ALU_ISSUE_ACC_EN
        .in_acc    (in_acc),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_w     (alu_w),
        .alu_c     (alu_c),
        .alu_z     (alu_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_f     (out_f)
    );

    alu_issue_stage #(.WIDTH(8), .SETTLE_CYCLES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .in_f      (in_f1),
`ifdef ALU_ISSUE_ACC_EN
        .in_acc    (1'b0),
`endif
        .alu_a     (alu_a1),
        .alu_b     (alu_b1),
        .alu_f     (alu_f1),
        .alu_w     (alu_w1),
        .alu_c     (alu_c1),
        .alu_z     (alu_z1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_w     (out_w1),
        .out_c     (out_c1),
        .out_z     (out_z1),
        .out_f     (out_f1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] f;
        logic [7:0] w;
        logic       c;
        logic       z;
    } vec_t;

    typedef struct packed {
        logic [7:0] w;
        logic       c;
        logic       z;
        logic [2:0] f;
    } res_t;

    res_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshakes complete at the next rising edge; inputs are stable by negedge+2.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_result: got w=%0h expected no result", out_w);
                end else begin
                    r = sb.pop_front();
                    check("result{w,c,z,f}", {19'd0, out_w, out_c, out_z, out_f}, 32'(r));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where out_valid rises.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                         input logic [7:0] ew, input logic ec, input logic ez,
                         input logic [7:0] exp_alu_a);
        int n;
        int lat;
        bit stable;
        in_a = a; in_b = b; in_f = f; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        sb.push_back({ew, ec, ez, f});
        @(negedge clk);
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_f = ~f;
        check("alu_a_load", {24'd0, alu_a}, {24'd0, exp_alu_a});
        check("alu_b_load", {24'd0, alu_b}, {24'd0, b});
        check("alu_f_load", {29'd0, alu_f}, {29'd0, f});
        lat = 0;
        stable = 1'b1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (alu_a !== exp_alu_a || alu_b !== b || alu_f !== f) stable = 1'b0;
        end
        check("latency", 32'(lat), SC);
        check("alu_hold", {31'd0, stable}, 32'd1);
        check("out_f_tag", {29'd0, out_f}, {29'd0, f});
    endtask

    initial begin
        vec_t vecs[7];
        int   idx, last_pulse, pulses, bad_spacing, alu_changed, seen;
        bit   acc_now;
        logic [7:0] pa, pb;
        logic [2:0] pf;

        vecs[0] = '{8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{8'h37, 8'hA5, 3'b100, 8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'h0F, 8'hF0, 3'b101, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h0F, 8'hF0, 3'b110, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h05, 8'h07, 3'b001, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 3'b111, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_f = 3'd0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_a1 = 8'h00; in_b1 = 8'h00; in_f1 = 3'd0; out_ready1 = 1'b1;
`ifdef ALU_ISSUE_ACC_EN
        in_acc = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);
        check("rst_alu_f", {29'd0, alu_f}, 32'd0);
        check("rst_out_w", {24'd0, out_w}, 32'd0);
        check("rst_out_czf", {27'd0, out_c, out_z, out_f}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].w, vecs[i].c, vecs[i].z, vecs[i].a);
        end
        @(negedge clk);

        // Backpressure: result must hold and no new op may enter while out_ready=0
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 3'b000, 8'h46, 1'b0, 1'b0, 8'h12);
        in_a = 8'h01; in_b = 8'h01; in_f = 3'b000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_w", {24'd0, out_w}, 32'h46);
            check("bp_alu_a", {24'd0, alu_a}, 32'h12);
            check("bp_alu_b", {24'd0, alu_b}, 32'h34);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back({8'h02, 1'b0, 1'b0, 3'b000});
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_same_cycle_load", {24'd0, alu_a}, 32'h01);
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        seen = 0;
        while (!out_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("bp_next_latency", 32'(seen), SC);
        @(negedge clk);

        // Back-to-back with in_valid and out_ready held high
        idx = 3; last_pulse = -1; pulses = 0; bad_spacing = 0; alu_changed = 0;
        in_a = vecs[idx].a; in_b = vecs[idx].b; in_f = vecs[idx].f; in_valid = 1'b1;
        pa = alu_a; pb = alu_b; pf = alu_f;
        for (int cyc = 0; cyc < 24; cyc++) begin
            #1;
            acc_now = in_valid && in_ready;
            if (acc_now) sb.push_back({vecs[idx].w, vecs[idx].c, vecs[idx].z, vecs[idx].f});
            @(negedge clk);
            if (!acc_now && (alu_a !== pa || alu_b !== pb || alu_f !== pf)) alu_changed++;
            pa = alu_a; pb = alu_b; pf = alu_f;
            if (out_valid) begin
                if (last_pulse >= 0 && cyc - last_pulse != SC + 1) bad_spacing++;
                last_pulse = cyc;
                pulses++;
            end
            if (acc_now) begin
                idx++;
                if (idx < 7) begin
                    in_a = vecs[idx].a; in_b = vecs[idx].b; in_f = vecs[idx].f;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd4);
        check("b2b_spacing", 32'(bad_spacing), 32'd0);
        check("b2b_alu_stable", 32'(alu_changed), 32'd0);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Reset during SETTLE discards the operation
        in_a = 8'h5A; in_b = 8'h11; in_f = 3'b000; in_valid = 1'b1;
        #1;
        check("rs_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rs_out_valid", {31'd0, out_valid}, 32'd0);
        check("rs_alu_a", {24'd0, alu_a}, 32'd0);
        check("rs_out_w", {24'd0, out_w}, 32'd0);
        check("rs_out_czf", {27'd0, out_c, out_z, out_f}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rs_in_ready_release", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rs_no_result", 32'(seen), 32'd0);

        // SETTLE_CYCLES=1 instance: capture on the first edge after accept
        in_a1 = 8'h33; in_b1 = 8'h44; in_f1 = 3'b000; in_valid1 = 1'b1;
        #1;
        check("s1_in_ready", {31'd0, in_ready1}, 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        check("s1_valid_after_accept", {31'd0, out_valid1}, 32'd0);
        @(negedge clk);
        check("s1_valid", {31'd0, out_valid1}, 32'd1);
        check("s1_result", {19'd0, out_w1, out_c1, out_z1, out_f1}, {19'd0, 8'h77, 5'd0});
        @(negedge clk);
        check("s1_valid_drop", {31'd0, out_valid1}, 32'd0);
        check("s1_in_ready_idle", {31'd0, in_ready1}, 32'd1);

`ifdef ALU_ISSUE_ACC_EN
        issue(8'h01, 8'h02, 3'b000, 8'h03, 1'b0, 1'b0, 8'h01);
        in_acc = 1'b1;
        issue(8'hFF, 8'h04, 3'b000, 8'h07, 1'b0, 1'b0, 8'h03);
        in_acc = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
